flash_adc_pipe: RTL and testbench



---
 rtl/flash_adc_pipe_if.sv | 24 ++
 rtl/flash_adc_pipe.sv | 160 ++++++++++++++++
 tb/tb_flash_adc_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_adc_pipe_if.sv
// Bus bundle for flash_adc_pipe.
// master: sample source (drives vin, vref, in_valid, flush; observes results).
// slave : converter (observes samples; drives dout, dout_valid, overrange).
interface flash_adc_pipe_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] vin;
  logic [N-1:0] vref;
  logic         in_valid;
  logic         flush;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         overrange;

  modport master (
    output vin, vref, in_valid, flush,
    input  dout, dout_valid, overrange
  );

  modport slave (
    input  vin, vref, in_valid, flush,
    output dout, dout_valid, overrange
  );
endinterface

// File: rtl/flash_adc_pipe.sv
// Pipelined ideal flash converter: capture -> compare -> encode -> (average) -> output.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears every register
//   bus    : slave side of flash_adc_pipe_if
//            vin/vref/in_valid sample input, flush synchronous pipeline clear,
//            dout/dout_valid/overrange registered result
module flash_adc_pipe #(
  parameter int unsigned N        = 8,
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  flash_adc_pipe_if.slave   bus
);

  localparam int unsigned NTAP = 2 ** N;
  localparam int unsigned W2   = 2 * N;
  localparam int unsigned ACCW = N + AVG_LOG2;

  logic [N-1:0]    vin_s_q, vin_s_d;
  logic [N-1:0]    vref_s_q, vref_s_d;
  logic            v1_q, v1_d;
  logic [NTAP-1:0] th_q, th_d;
  logic            v2_q, v2_d;
  logic [N-1:0]    code_q, code_d;
  logic            sat_q, sat_d;
  logic            v3_q, v3_d;
  logic [N-1:0]    dout_q, dout_d;
  logic            dv_q, dv_d;
  logic            ovr_q, ovr_d;
  logic [W2-1:0]   ref_c;

  // Capture stage: flush discards a sample offered in the same cycle.
  always_comb begin
    vin_s_d  = vin_s_q;
    vref_s_d = vref_s_q;
    v1_d     = bus.in_valid & ~bus.flush;
    if (v1_d) begin
      vin_s_d  = bus.vin;
      vref_s_d = bus.vref;
    end
  end

  // Compare stage: product kept at 2N bits so the tap is exact before the shift.
  always_comb begin
    th_d  = '0;
    ref_c = '0;
    for (int i = 1; i < NTAP; i++) begin
      ref_c   = (W2'(i) * W2'(vref_s_q)) >> N;
      th_d[i] = W2'(vin_s_q) > ref_c;
    end
    v2_d = v1_q & ~bus.flush;
  end

  // Encode stage: highest set comparator wins (th[0] is always 0).
  always_comb begin
    code_d = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (th_q[i]) code_d = N'(i);
    end
    sat_d = th_q[NTAP-1];
    v3_d  = v2_q & ~bus.flush;
  end

  generate
    if (AVG_LOG2 == 0) begin : g_direct
      // Every conversion is presented directly.
      always_comb begin
        dout_d = dout_q;
        ovr_d  = ovr_q;
        dv_d   = 1'b0;
        if (!bus.flush && v3_q) begin
          dout_d = code_q;
          ovr_d  = sat_q;
          dv_d   = 1'b1;
        end
      end
    end else begin : g_avg
      logic [ACCW-1:0]     acc_q, acc_d, sum_c;
      logic [AVG_LOG2-1:0] cnt_q, cnt_d;
      logic                sticky_q, sticky_d;

      // Block averager: the last conversion of a block is folded in combinationally.
      always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dout_d   = dout_q;
        ovr_d    = ovr_q;
        dv_d     = 1'b0;
        sum_c    = acc_q + ACCW'(code_q);
        if (bus.flush) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else if (v3_q) begin
          if (&cnt_q) begin
            dout_d   = N'(sum_c >> AVG_LOG2);
            ovr_d    = sticky_q | sat_q;
            dv_d     = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
          end else begin
            acc_d    = sum_c;
            cnt_d    = cnt_q + AVG_LOG2'(1);
            sticky_d = sticky_q | sat_q;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q    <= '0;
          cnt_q    <= '0;
          sticky_q <= 1'b0;
        end else begin
          acc_q    <= acc_d;
          cnt_q    <= cnt_d;
          sticky_q <= sticky_d;
        end
      end
    end
  endgenerate

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_s_q  <= '0;
      vref_s_q <= '0;
      v1_q     <= 1'b0;
      th_q     <= '0;
      v2_q     <= 1'b0;
      code_q   <= '0;
      sat_q    <= 1'b0;
      v3_q     <= 1'b0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      vin_s_q  <= vin_s_d;
      vref_s_q <= vref_s_d;
      v1_q     <= v1_d;
      th_q     <= th_d;
      v2_q     <= v2_d;
      code_q   <= code_d;
      sat_q    <= sat_d;
      v3_q     <= v3_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.overrange  = ovr_q;

endmodule

// File: tb/tb_flash_adc_pipe.sv
// Bench for flash_adc_pipe: one instance without averaging, one averaging 4.
module tb_flash_adc_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flash_adc_pipe_if #(.N(8)) bus0 ();
  flash_adc_pipe_if #(.N(8)) bus2 ();

  assign bus2.vin      = bus0.vin;
  assign bus2.vref     = bus0.vref;
  assign bus2.in_valid = bus0.in_valid;
  assign bus2.flush    = bus0.flush;

  flash_adc_pipe #(.N(8), .AVG_LOG2(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  flash_adc_pipe #(.N(8), .AVG_LOG2(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] conv_code(input logic [7:0] v, input logic [7:0] r);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 1; i < 256; i++) begin
      if (((i * int'(r)) >> 8) < int'(v)) c = 8'(i);
    end
    return c;
  endfunction

  function automatic logic conv_sat(input logic [7:0] v, input logic [7:0] r);
    return int'(v) > ((255 * int'(r)) >> 8);
  endfunction

  // Scoreboard model: 3-deep conversion pipe feeding per-instance expectation queues.
  logic [8:0] q0[$];
  logic [8:0] q2[$];
  logic [2:0] p_v;
  logic [7:0] p_c[3];
  logic [2:0] p_s;
  int         acc_m;
  int         cnt_m;
  logic       sticky_m;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      p_v      <= '0;
      p_s      <= '0;
      acc_m    <= 0;
      cnt_m    <= 0;
      sticky_m <= 1'b0;
      q0.delete();
      q2.delete();
    end else if (bus0.flush) begin
      p_v      <= '0;
      acc_m    <= 0;
      cnt_m    <= 0;
      sticky_m <= 1'b0;
    end else begin
      p_v    <= {p_v[1:0], bus0.in_valid};
      p_c[0] <= conv_code(bus0.vin, bus0.vref);
      p_s[0] <= conv_sat(bus0.vin, bus0.vref);
      p_c[1] <= p_c[0];
      p_c[2] <= p_c[1];
      p_s[2:1] <= p_s[1:0];
      if (p_v[2]) begin
        q0.push_back({p_s[2], p_c[2]});
        if (cnt_m == 3) begin
          q2.push_back({sticky_m | p_s[2], 8'((acc_m + int'(p_c[2])) >> 2)});
          acc_m    <= 0;
          cnt_m    <= 0;
          sticky_m <= 1'b0;
        end else begin
          acc_m    <= acc_m + int'(p_c[2]);
          cnt_m    <= cnt_m + 1;
          sticky_m <= sticky_m | p_s[2];
        end
      end
    end
  end

  // Output monitors: every dout_valid must match the next queued expectation, in the same cycle.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (rst_n) begin
      if (bus0.dout_valid || q0.size() > 0) begin
        check("sb0_valid", 32'(bus0.dout_valid), 32'(q0.size() > 0));
        if (bus0.dout_valid && q0.size() > 0) begin
          e = q0.pop_front();
          check("sb0_dout", 32'(bus0.dout), 32'(e[7:0]));
          check("sb0_ovr", 32'(bus0.overrange), 32'(e[8]));
        end
      end
      if (bus2.dout_valid || q2.size() > 0) begin
        check("sb2_valid", 32'(bus2.dout_valid), 32'(q2.size() > 0));
        if (bus2.dout_valid && q2.size() > 0) begin
          e = q2.pop_front();
          check("sb2_dout", 32'(bus2.dout), 32'(e[7:0]));
          check("sb2_ovr", 32'(bus2.overrange), 32'(e[8]));
        end
      end
    end
  end

  task automatic send(input logic [7:0] v, input logic [7:0] r);
    bus0.vin      = v;
    bus0.vref     = r;
    bus0.in_valid = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus0.flush = 1'b1;
    @(negedge clk);
    bus0.flush = 1'b0;
  endtask

  // Single sample on the direct instance: valid low at +3, pulse at +4, low again at +5.
  task automatic single0(input string tag, input logic [7:0] v, input logic [7:0] r,
                         input logic [7:0] ed, input logic eo);
    send(v, r);
    repeat (2) @(negedge clk);
    check({tag, "_early"}, 32'(bus0.dout_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus0.dout_valid), 32'd1);
    check({tag, "_dout"}, 32'(bus0.dout), 32'(ed));
    check({tag, "_ovr"}, 32'(bus0.overrange), 32'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus0.dout_valid), 32'd0);
  endtask

  task automatic wait_dv2(input string tag, input logic [7:0] ed, input logic eo);
    int n;
    n = 0;
    while (bus2.dout_valid !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(bus2.dout_valid), 32'd1);
    check({tag, "_dout"}, 32'(bus2.dout), 32'(ed));
    check({tag, "_ovr"}, 32'(bus2.overrange), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus0.vin      = '0;
    bus0.vref     = '0;
    bus0.in_valid = 1'b0;
    bus0.flush    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout0", 32'(bus0.dout), 32'd0);
    check("rst_dv0", 32'(bus0.dout_valid), 32'd0);
    check("rst_ovr0", 32'(bus0.overrange), 32'd0);
    check("rst_dout2", 32'(bus2.dout), 32'd0);
    check("rst_dv2", 32'(bus2.dout_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single0("mid", 8'd128, 8'd255, 8'd128, 1'b0);
    single0("zero", 8'd0, 8'd255, 8'd0, 1'b0);
    single0("full", 8'd255, 8'd255, 8'd255, 1'b1);
    single0("vref0", 8'd1, 8'd0, 8'd255, 1'b1);

    // Back-to-back: outputs on four consecutive cycles, first one as the last sample enters.
    send(8'd10, 8'd255);
    send(8'd20, 8'd255);
    send(8'd30, 8'd255);
    send(8'd40, 8'd255);
    check("b2b_0", 32'(bus0.dout), 32'd10);
    @(negedge clk);
    check("b2b_1", 32'(bus0.dout), 32'd20);
    @(negedge clk);
    check("b2b_2", 32'(bus0.dout), 32'd30);
    @(negedge clk);
    check("b2b_3", 32'(bus0.dout), 32'd40);
    check("b2b_3v", 32'(bus0.dout_valid), 32'd1);
    repeat (3) @(negedge clk);

    // Flush two cycles after the sample: it never emerges, dout holds 40.
    send(8'd50, 8'd255);
    @(negedge clk);
    do_flush();
    repeat (5) @(negedge clk);
    check("flush_hold", 32'(bus0.dout), 32'd40);
    check("flush_nodv", 32'(bus0.dout_valid), 32'd0);

    // Averaging by four.
    send(8'd10, 8'd255);
    send(8'd11, 8'd255);
    send(8'd12, 8'd255);
    send(8'd13, 8'd255);
    wait_dv2("avg_a", 8'd11, 1'b0);
    send(8'd10, 8'd255);
    send(8'd11, 8'd255);
    send(8'd255, 8'd255);
    send(8'd13, 8'd255);
    wait_dv2("avg_ovr", 8'd72, 1'b1);
    send(8'd10, 8'd255);
    send(8'd11, 8'd255);
    send(8'd12, 8'd255);
    send(8'd13, 8'd255);
    wait_dv2("avg_clr", 8'd11, 1'b0);

    // Three samples accumulated then flushed: next output reflects only the new four.
    send(8'd200, 8'd255);
    send(8'd200, 8'd255);
    send(8'd200, 8'd255);
    repeat (5) @(negedge clk);
    check("avgfl_none", 32'(bus2.dout_valid), 32'd0);
    do_flush();
    send(8'd20, 8'd255);
    send(8'd20, 8'd255);
    send(8'd20, 8'd255);
    send(8'd20, 8'd255);
    wait_dv2("avg_flush", 8'd20, 1'b0);
    repeat (4) @(negedge clk);

    // Asynchronous reset between edges with a conversion in flight.
    send(8'd77, 8'd255);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout0", 32'(bus0.dout), 32'd0);
    check("arst_ovr0", 32'(bus0.overrange), 32'd0);
    check("arst_dout2", 32'(bus2.dout), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    single0("post_rst", 8'd90, 8'd255, 8'd90, 1'b0);

    repeat (6) @(negedge clk);
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q2_empty", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
